key_press_classifier: RTL and testbench



---
 rtl/key_press_classifier.sv | 175 +++++++++++++++++
 tb/tb_key_press_classifier.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_press_classifier.sv
// ---------------------------------------------------------------------------
// key_press_classifier
//
// Purpose:
//   Turns the debounced key level into one-cycle gesture events for the
//   menu/control logic: press/release edges, short press, long press,
//   auto-repeat while held after a long press, and double click.
//
// Ports:
//   clk           in   system clock
//   reset         in   asynchronous, active-high reset
//   key_in        in   debounced key level, 1 = pressed (synchronous to clk)
//   pressed       out  registered copy of key_in
//   key_down      out  one-cycle pulse after the press edge
//   key_up        out  one-cycle pulse after the release edge
//   short_press   out  one-cycle pulse, single short press confirmed
//   long_press    out  one-cycle pulse, hold reached LONG_CYCLES
//   repeat_tick   out  one-cycle pulse every REPEAT_CYCLES during a long hold
//   double_click  out  one-cycle pulse on a second press within the gap
//
// All outputs are registered. LONG_CYCLES, GAP_CYCLES and REPEAT_CYCLES must
// be >= 2 and < 2**CNT_W.
// ---------------------------------------------------------------------------
module key_press_classifier #(
    parameter int LONG_CYCLES   = 25000000,
    parameter int GAP_CYCLES    = 15000000,
    parameter int REPEAT_CYCLES = 5000000,
    parameter int CNT_W         = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic key_in,
    output logic pressed,
    output logic key_down,
    output logic key_up,
    output logic short_press,
    output logic long_press,
    output logic repeat_tick,
    output logic double_click
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRESS1    = 3'd1,
        ST_WAIT2     = 3'd2,
        ST_PRESS2    = 3'd3,
        ST_LONG_HOLD = 3'd4
    } state_t;

    // The counter holds (edges since state entry - 1), so the terminal edge
    // of each window is the one that sees the counter at limit-1.
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_prev_q;
    logic             key_down_q, key_up_q;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;
    logic             double_q, double_d;
    logic             rise_s, fall_s;

    // Edge detection against the previous sample; key_prev_q is 0 after
    // reset, so a key held through reset release is seen as a fresh press.
    assign rise_s = key_in & ~key_prev_q;
    assign fall_s = ~key_in & key_prev_q;

    // Next-state, counter and gesture-pulse decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        short_d  = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;
        double_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rise_s) begin
                    state_d = ST_PRESS1;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRESS1: begin
                if (!key_in) begin
                    state_d = ST_WAIT2;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    state_d = ST_LONG_HOLD;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT2: begin
                // A press on the last window edge wins over the timeout.
                if (key_in) begin
                    double_d = 1'b1;
                    state_d  = ST_PRESS2;
                    cnt_d    = CNT_ZERO;
                end else if (cnt_q == GAP_LAST) begin
                    short_d = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_PRESS2: begin
                if (!key_in) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = ST_PRESS2;
                end
            end
            ST_LONG_HOLD: begin
                if (!key_in) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == REP_LAST) begin
                    repeat_d = 1'b1;
                    cnt_d    = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State, counter, key history and registered output pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= CNT_ZERO;
            key_prev_q <= 1'b0;
            key_down_q <= 1'b0;
            key_up_q   <= 1'b0;
            short_q    <= 1'b0;
            long_q     <= 1'b0;
            repeat_q   <= 1'b0;
            double_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            key_prev_q <= key_in;
            key_down_q <= rise_s;
            key_up_q   <= fall_s;
            short_q    <= short_d;
            long_q     <= long_d;
            repeat_q   <= repeat_d;
            double_q   <= double_d;
        end
    end

    assign pressed      = key_prev_q;
    assign key_down     = key_down_q;
    assign key_up       = key_up_q;
    assign short_press  = short_q;
    assign long_press   = long_q;
    assign repeat_tick  = repeat_q;
    assign double_click = double_q;

endmodule

// File: tb/tb_key_press_classifier.sv
// ---------------------------------------------------------------------------
// tb_key_press_classifier
//
// Directed bench for key_press_classifier with LONG=8, GAP=5, REPEAT=3,
// CNT_W=4. Each scenario task drives key_in one clock at a time; t=0 is the
// first edge of the scenario and the output vector is compared after every
// edge against hand-derived expectations:
//   outs = {pressed, key_down, key_up, short_press, long_press,
//           repeat_tick, double_click}
// ---------------------------------------------------------------------------
module tb_key_press_classifier;

    logic clk;
    logic reset;
    logic key_in;
    logic pressed, key_down, key_up, short_press, long_press, repeat_tick, double_click;
    logic [6:0] outs;
    logic [6:0] exp_v;
    logic       kv;
    int checks;
    int passed;

    key_press_classifier #(
        .LONG_CYCLES  (8),
        .GAP_CYCLES   (5),
        .REPEAT_CYCLES(3),
        .CNT_W        (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_in      (key_in),
        .pressed     (pressed),
        .key_down    (key_down),
        .key_up      (key_up),
        .short_press (short_press),
        .long_press  (long_press),
        .repeat_tick (repeat_tick),
        .double_click(double_click)
    );

    assign outs = {pressed, key_down, key_up, short_press, long_press, repeat_tick, double_click};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Let the key rest low without checking, returning the DUT to idle.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            key_in = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        key_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (outs !== 7'b0000000)
            $display("FAIL reset_state got %b expected %b", outs, 7'b0000000);
        else
            passed++;
        reset = 1'b0;
        idle(2);
        checks++;
        if (outs !== 7'b0000000)
            $display("FAIL post_reset_idle got %b expected %b", outs, 7'b0000000);
        else
            passed++;
    endtask

    // Press 3 cycles: key_down t0, key_up t3, short_press t8.
    task automatic test_short();
        for (int t = 0; t <= 10; t++) begin
            kv = (t < 3);
            key_in = kv;
            @(posedge clk);
            #1;
            exp_v = {kv, t == 0, t == 3, t == 8, 1'b0, 1'b0, 1'b0};
            checks++;
            if (outs !== exp_v)
                $display("FAIL short t=%0d got %b expected %b", t, outs, exp_v);
            else
                passed++;
        end
    endtask

    // Hold 16 cycles: long t8, repeat t11 and t14, key_up t16.
    task automatic test_long();
        for (int t = 0; t <= 22; t++) begin
            kv = (t < 16);
            key_in = kv;
            @(posedge clk);
            #1;
            exp_v = {kv, t == 0, t == 16, 1'b0, t == 8, (t == 11) || (t == 14), 1'b0};
            checks++;
            if (outs !== exp_v)
                $display("FAIL long t=%0d got %b expected %b", t, outs, exp_v);
            else
                passed++;
        end
    endtask

    // Press 2, release at t2, re-press at t4 held 20: double with key_down t4.
    task automatic test_double();
        for (int t = 0; t <= 30; t++) begin
            kv = (t < 2) || ((t >= 4) && (t < 24));
            key_in = kv;
            @(posedge clk);
            #1;
            exp_v = {kv, (t == 0) || (t == 4), (t == 2) || (t == 24), 1'b0, 1'b0, 1'b0, t == 4};
            checks++;
            if (outs !== exp_v)
                $display("FAIL double t=%0d got %b expected %b", t, outs, exp_v);
            else
                passed++;
        end
    endtask

    // Re-press exactly at R0+5 is a double; at R0+6 it follows a short.
    task automatic test_gap_boundary();
        for (int t = 0; t <= 15; t++) begin
            kv = (t < 1) || ((t >= 6) && (t < 8));
            key_in = kv;
            @(posedge clk);
            #1;
            exp_v = {kv, (t == 0) || (t == 6), (t == 1) || (t == 8), 1'b0, 1'b0, 1'b0, t == 6};
            checks++;
            if (outs !== exp_v)
                $display("FAIL gap_in t=%0d got %b expected %b", t, outs, exp_v);
            else
                passed++;
        end
        for (int t = 0; t <= 16; t++) begin
            kv = (t < 1) || ((t >= 7) && (t < 9));
            key_in = kv;
            @(posedge clk);
            #1;
            exp_v = {kv, (t == 0) || (t == 7), (t == 1) || (t == 9),
                     (t == 6) || (t == 14), 1'b0, 1'b0, 1'b0};
            checks++;
            if (outs !== exp_v)
                $display("FAIL gap_out t=%0d got %b expected %b", t, outs, exp_v);
            else
                passed++;
        end
    endtask

    // Release at E0+8 is short; release at E0+9 gives long at t8.
    task automatic test_long_boundary();
        for (int t = 0; t <= 15; t++) begin
            kv = (t < 8);
            key_in = kv;
            @(posedge clk);
            #1;
            exp_v = {kv, t == 0, t == 8, t == 13, 1'b0, 1'b0, 1'b0};
            checks++;
            if (outs !== exp_v)
                $display("FAIL long_edge8 t=%0d got %b expected %b", t, outs, exp_v);
            else
                passed++;
        end
        for (int t = 0; t <= 15; t++) begin
            kv = (t < 9);
            key_in = kv;
            @(posedge clk);
            #1;
            exp_v = {kv, t == 0, t == 9, 1'b0, t == 8, 1'b0, 1'b0};
            checks++;
            if (outs !== exp_v)
                $display("FAIL long_edge9 t=%0d got %b expected %b", t, outs, exp_v);
            else
                passed++;
        end
    endtask

    // Reset during LONG_HOLD with key held, then release reset with key held.
    task automatic test_reset_mid_gesture();
        for (int t = 0; t <= 8; t++) begin
            key_in = 1'b1;
            @(posedge clk);
            #1;
            exp_v = {1'b1, t == 0, 1'b0, 1'b0, t == 8, 1'b0, 1'b0};
            checks++;
            if (outs !== exp_v)
                $display("FAIL pre_reset t=%0d got %b expected %b", t, outs, exp_v);
            else
                passed++;
        end
        reset = 1'b1;
        #1;
        checks++;
        if (outs !== 7'b0000000)
            $display("FAIL async_reset got %b expected %b", outs, 7'b0000000);
        else
            passed++;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (outs !== 7'b0000000)
            $display("FAIL held_reset got %b expected %b", outs, 7'b0000000);
        else
            passed++;
        reset = 1'b0;
        for (int t = 0; t <= 15; t++) begin
            kv = (t < 13);
            key_in = kv;
            @(posedge clk);
            #1;
            exp_v = {kv, t == 0, t == 13, 1'b0, t == 8, t == 11, 1'b0};
            checks++;
            if (outs !== exp_v)
                $display("FAIL post_reset t=%0d got %b expected %b", t, outs, exp_v);
            else
                passed++;
        end
    endtask

    initial begin
        checks = 0;
        passed = 0;
        reset  = 1'b1;
        key_in = 1'b0;
        test_reset();
        test_short();
        idle(2);
        test_long();
        idle(2);
        test_double();
        idle(2);
        test_gap_boundary();
        idle(2);
        test_long_boundary();
        idle(2);
        test_reset_mid_gesture();
        idle(2);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
